// File: rtl/tlul_host_pkg.sv
// Shared types for the TL-UL host adapter: A-channel state and per-source slot record.
package tlul_host_pkg;
  localparam int unsigned IdW = 3;

  typedef enum logic {
    A_IDLE = 1'b0,
    A_SEND = 1'b1
  } a_state_e;

  typedef struct packed {
    logic busy;
    logic we;
  } slot_t;
endpackage

// File: rtl/tlul_pkg.sv
// TL-UL channel opcode encodings shared by hosts and devices.
package tlul_pkg;
  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;
endpackage

// File: rtl/tlul_host_srcid_alloc.sv
// Source-ID allocator: busy bitmap, lowest-free pick and full flag.
module tlul_host_srcid_alloc
  import tlul_host_pkg::*;
#(
  parameter int unsigned NumIds = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              alloc_i,
  input  logic              free_i,
  input  logic [IdW-1:0]    free_id_i,
  output logic [NumIds-1:0] busy_o,
  output logic [IdW-1:0]    alloc_id_o,
  output logic              full_o
);
  logic [NumIds-1:0] busy_q, alloc_mask, free_mask;

  // Scan downward so the lowest free index wins.
  always_comb begin
    alloc_id_o = '0;
    for (int i = NumIds - 1; i >= 0; i--)
      if (!busy_q[i]) alloc_id_o = IdW'(i);
  end

  always_comb begin
    alloc_mask = '0;
    free_mask  = '0;
    for (int i = 0; i < NumIds; i++) begin
      alloc_mask[i] = alloc_i && (alloc_id_o == IdW'(i));
      free_mask[i]  = free_i && (free_id_i == IdW'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= (busy_q & ~free_mask) | alloc_mask;
  end

  assign busy_o = busy_q;
  assign full_o = &busy_q;
endmodule

// File: rtl/tlul_host_adapter.sv
// Simple req/gnt/rvalid host bus to TL-UL host bridge with source-ID tracking and watchdog.
module tlul_host_adapter
  import tlul_pkg::*;
  import tlul_host_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned TimeoutCycles  = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        rerr_o,
  output logic [2:0]  rid_o,
  output logic        a_valid,
  output logic [2:0]  a_bits_opcode,
  output logic [2:0]  a_bits_param,
  output logic [1:0]  a_bits_size,
  output logic [7:0]  a_bits_source,
  output logic [31:0] a_bits_address,
  output logic [3:0]  a_bits_mask,
  output logic [31:0] a_bits_data,
  input  logic        a_ready,
  input  logic        d_valid,
  input  logic [2:0]  d_bits_opcode,
  input  logic [2:0]  d_bits_param,
  input  logic [1:0]  d_bits_size,
  input  logic [7:0]  d_bits_source,
  input  logic [0:0]  d_bits_sink,
  input  logic [31:0] d_bits_data,
  input  logic [0:0]  d_bits_denied,
  output logic        d_ready,
  output logic        timeout_o,
  output logic        unexp_rsp_o
);
  localparam int unsigned WdW = $clog2(TimeoutCycles + 1);

  a_state_e                  state_q, state_d;
  logic [MaxOutstanding-1:0] busy, we_q;
  logic [IdW-1:0]            alloc_id, d_id;
  logic                      full, a_hs, d_hs, d_known, d_rerr;
  slot_t                     d_slot;
  logic [WdW-1:0]            wd_cnt;
  logic                      unused_in;

  assign unused_in = ^{d_bits_param, d_bits_size, d_bits_sink, addr_i[1:0]};

  assign a_hs = a_valid & a_ready;

  always_comb begin
    state_d = state_q;
    gnt_o   = 1'b0;
    a_valid = (state_q == A_SEND);
    if (rst_ni && req_i && !full && !timeout_o && (state_q == A_IDLE || a_ready))
      gnt_o = 1'b1;
    if (gnt_o)     state_d = A_SEND;
    else if (a_hs) state_d = A_IDLE;
  end

  // Sources outside 0..MaxOutstanding-1 never match a slot and so read as not busy.
  assign d_hs = d_valid & d_ready;
  assign d_id = d_bits_source[IdW-1:0];
  always_comb begin
    d_slot = '0;
    for (int i = 0; i < MaxOutstanding; i++)
      if (d_id == IdW'(i)) begin
        d_slot.busy = busy[i];
        d_slot.we   = we_q[i];
      end
    if (d_bits_source[7:IdW] != '0) d_slot = '0;
  end
  assign d_known = d_hs & d_slot.busy;
  assign d_rerr  = d_bits_denied[0] |
                   (d_slot.we ? (d_bits_opcode != AccessAck) : (d_bits_opcode != AccessAckData));

  tlul_host_srcid_alloc #(.NumIds(MaxOutstanding)) u_srcid_alloc (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .alloc_i    (gnt_o),
    .free_i     (d_known),
    .free_id_i  (d_id),
    .busy_o     (busy),
    .alloc_id_o (alloc_id),
    .full_o     (full)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= A_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a_bits_opcode  <= '0;
      a_bits_param   <= '0;
      a_bits_size    <= '0;
      a_bits_source  <= '0;
      a_bits_address <= '0;
      a_bits_mask    <= '0;
      a_bits_data    <= '0;
      we_q           <= '0;
    end else if (gnt_o) begin
      a_bits_opcode  <= we_i ? ((be_i == 4'hF) ? PutFullData : PutPartialData) : Get;
      a_bits_param   <= '0;
      a_bits_size    <= 2'd2;
      a_bits_source  <= 8'(alloc_id);
      a_bits_address <= {addr_i[31:2], 2'b00};
      a_bits_mask    <= we_i ? be_i : 4'hF;
      a_bits_data    <= we_i ? wdata_i : 32'h0;
      for (int i = 0; i < MaxOutstanding; i++)
        if (alloc_id == IdW'(i)) we_q[i] <= we_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_o    <= 1'b0;
      rdata_o     <= '0;
      rerr_o      <= 1'b0;
      rid_o       <= '0;
      d_ready     <= 1'b1;
      unexp_rsp_o <= 1'b0;
    end else begin
      d_ready  <= 1'b1;
      rvalid_o <= d_known;
      rerr_o   <= d_known & d_rerr;
      if (d_known) begin
        rid_o   <= d_id;
        rdata_o <= d_slot.we ? 32'h0 : d_bits_data;
      end
      if (d_hs && !d_known) unexp_rsp_o <= 1'b1;
    end
  end

  // Watchdog only runs while something is outstanding and nothing comes back.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wd_cnt    <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (d_hs || busy == '0)                     wd_cnt <= '0;
      else if (wd_cnt != WdW'(TimeoutCycles - 1)) wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt == WdW'(TimeoutCycles - 1))      timeout_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_tlul_host_adapter.sv
// Directed bench for tlul_host_adapter: vector table plus multi-cycle corner sequences.
module tb_tlul_host_adapter;
  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        req_i = 1'b0, we_i = 1'b0;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic [3:0]  be_i = '0;
  logic        gnt_o, rvalid_o, rerr_o;
  logic [31:0] rdata_o;
  logic [2:0]  rid_o;
  logic        a_valid, a_ready = 1'b0;
  logic [2:0]  a_bits_opcode, a_bits_param;
  logic [1:0]  a_bits_size;
  logic [7:0]  a_bits_source;
  logic [31:0] a_bits_address, a_bits_data;
  logic [3:0]  a_bits_mask;
  logic        d_valid = 1'b0;
  logic [2:0]  d_bits_opcode = '0, d_bits_param = '0;
  logic [1:0]  d_bits_size = '0;
  logic [7:0]  d_bits_source = '0;
  logic [0:0]  d_bits_sink = '0, d_bits_denied = '0;
  logic [31:0] d_bits_data = '0;
  logic        d_ready, timeout_o, unexp_rsp_o;

  int n_chk = 0, n_fail = 0;

  always #5 clk_i = ~clk_i;

  tlul_host_adapter dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .rerr_o(rerr_o), .rid_o(rid_o), .a_valid(a_valid),
    .a_bits_opcode(a_bits_opcode), .a_bits_param(a_bits_param), .a_bits_size(a_bits_size),
    .a_bits_source(a_bits_source), .a_bits_address(a_bits_address),
    .a_bits_mask(a_bits_mask), .a_bits_data(a_bits_data), .a_ready(a_ready),
    .d_valid(d_valid), .d_bits_opcode(d_bits_opcode), .d_bits_param(d_bits_param),
    .d_bits_size(d_bits_size), .d_bits_source(d_bits_source), .d_bits_sink(d_bits_sink),
    .d_bits_data(d_bits_data), .d_bits_denied(d_bits_denied), .d_ready(d_ready),
    .timeout_o(timeout_o), .unexp_rsp_o(unexp_rsp_o)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic [2:0]  d_op;
    logic        d_den;
    logic [31:0] d_data;
    logic [2:0]  e_op;
    logic [3:0]  e_mask;
    logic [31:0] e_addr, e_data, e_rdata;
    logic        e_rerr;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic d_send(input logic [7:0] src, input logic [2:0] op, input logic den,
                        input logic [31:0] data);
    d_valid = 1'b1; d_bits_source = src; d_bits_opcode = op;
    d_bits_denied = den; d_bits_data = data;
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'h1004, 32'h0,      4'h0, 3'd1, 1'b0, 32'hDEADBEEF,
                3'd4, 4'hF, 32'h1004, 32'h0,      32'hDEADBEEF, 1'b0};
    vecs[1] = '{1'b1, 32'h2002, 32'h11223344, 4'h3, 3'd0, 1'b0, 32'h0,
                3'd1, 4'h3, 32'h2000, 32'h11223344, 32'h0, 1'b0};
    vecs[2] = '{1'b1, 32'h300C, 32'hA5A5A5A5, 4'hF, 3'd0, 1'b0, 32'h0,
                3'd0, 4'hF, 32'h300C, 32'hA5A5A5A5, 32'h0, 1'b0};
    vecs[3] = '{1'b0, 32'h0043, 32'h0,      4'hF, 3'd0, 1'b0, 32'h1234,
                3'd4, 4'hF, 32'h0040, 32'h0,      32'h1234, 1'b1};
    vecs[4] = '{1'b1, 32'h0500, 32'hCAFEF00D, 4'hF, 3'd0, 1'b1, 32'h0,
                3'd0, 4'hF, 32'h0500, 32'hCAFEF00D, 32'h0, 1'b1};
    vecs[5] = '{1'b1, 32'h0600, 32'h77,     4'h1, 3'd1, 1'b0, 32'hFFFF,
                3'd1, 4'h1, 32'h0600, 32'h77,     32'h0, 1'b1};
    vecs[6] = '{1'b0, 32'h0704, 32'h55,     4'h6, 3'd1, 1'b0, 32'h0BADCAFE,
                3'd4, 4'hF, 32'h0704, 32'h0,      32'h0BADCAFE, 1'b0};

    // Reset state
    tick(); tick();
    chk("rst_a_valid", 32'(a_valid), 0);
    chk("rst_gnt", 32'(gnt_o), 0);
    chk("rst_rvalid", 32'(rvalid_o), 0);
    chk("rst_rerr", 32'(rerr_o), 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_rid", 32'(rid_o), 0);
    chk("rst_timeout", 32'(timeout_o), 0);
    chk("rst_unexp", 32'(unexp_rsp_o), 0);
    chk("rst_a_fields", {a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
                         a_bits_mask, 12'h0}, 0);
    chk("rst_a_addr", a_bits_address, 0);
    chk("rst_a_data", a_bits_data, 0);
    rst_ni = 1'b1;
    tick();
    chk("d_ready_after_rst", 32'(d_ready), 1);

    // Single transactions from the vector table
    for (int i = 0; i < 7; i++) begin
      req_i = 1'b1; we_i = vecs[i].we; addr_i = vecs[i].addr; wdata_i = vecs[i].wdata;
      be_i = vecs[i].be; a_ready = 1'b1;
      #1 chk($sformatf("v%0d_gnt", i), 32'(gnt_o), 1);
      tick();
      req_i = 1'b0;
      #1;
      chk($sformatf("v%0d_a_valid", i), 32'(a_valid), 1);
      chk($sformatf("v%0d_opcode", i), 32'(a_bits_opcode), 32'(vecs[i].e_op));
      chk($sformatf("v%0d_mask", i), 32'(a_bits_mask), 32'(vecs[i].e_mask));
      chk($sformatf("v%0d_addr", i), a_bits_address, vecs[i].e_addr);
      chk($sformatf("v%0d_data", i), a_bits_data, vecs[i].e_data);
      chk($sformatf("v%0d_src_size_param", i),
          {24'h0, a_bits_source}, 0);
      chk($sformatf("v%0d_size_param", i), {27'h0, a_bits_size, a_bits_param}, {27'h0, 2'd2, 3'd0});
      tick();
      d_send(8'd0, vecs[i].d_op, vecs[i].d_den, vecs[i].d_data);
      #1 chk($sformatf("v%0d_a_valid_drop", i), 32'(a_valid), 0);
      tick();
      d_valid = 1'b0;
      #1;
      chk($sformatf("v%0d_rvalid", i), 32'(rvalid_o), 1);
      chk($sformatf("v%0d_rdata", i), rdata_o, vecs[i].e_rdata);
      chk($sformatf("v%0d_rerr", i), 32'(rerr_o), 32'(vecs[i].e_rerr));
      chk($sformatf("v%0d_rid", i), 32'(rid_o), 0);
      tick();
      chk($sformatf("v%0d_rvalid_pulse", i), 32'(rvalid_o), 0);
    end
    chk("no_unexp_yet", 32'(unexp_rsp_o), 0);

    // A-channel stall with held fields, then back-to-back grant on the handshake
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h2000; a_ready = 1'b0;
    #1 chk("stall_gnt0", 32'(gnt_o), 1);
    tick();
    addr_i = 32'h3000;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("stall%0d_a_valid", c), 32'(a_valid), 1);
      chk($sformatf("stall%0d_addr", c), a_bits_address, 32'h2000);
      chk($sformatf("stall%0d_gnt", c), 32'(gnt_o), 0);
      tick();
    end
    a_ready = 1'b1;
    #1 chk("stall_b2b_gnt", 32'(gnt_o), 1);
    tick();
    req_i = 1'b0;
    #1;
    chk("b2b_a_valid", 32'(a_valid), 1);
    chk("b2b_addr", a_bits_address, 32'h3000);
    chk("b2b_src", 32'(a_bits_source), 1);
    tick();
    chk("b2b_idle", 32'(a_valid), 0);
    d_send(8'd0, 3'd1, 1'b0, 32'h0);
    tick();
    d_send(8'd1, 3'd1, 1'b0, 32'h0);
    tick();
    d_valid = 1'b0;
    #1 chk("b2b_rid1", 32'(rid_o), 1);

    // Fill all source IDs, then free ID 2 and see it reused
    for (int k = 0; k < 4; k++) begin
      tick();
      req_i = 1'b1; addr_i = 32'h100 + 32'(4 * k);
      #1 chk($sformatf("fill%0d_gnt", k), 32'(gnt_o), 1);
      if (k > 0) chk($sformatf("fill%0d_prev_src", k), 32'(a_bits_source), 32'(k - 1));
    end
    tick();
    #1;
    chk("fill3_src", 32'(a_bits_source), 3);
    chk("full_gnt", 32'(gnt_o), 0);
    tick();
    d_send(8'd2, 3'd1, 1'b0, 32'h22);
    #1 chk("free_same_cycle_gnt", 32'(gnt_o), 0);
    tick();
    d_valid = 1'b0;
    #1;
    chk("free_next_gnt", 32'(gnt_o), 1);
    chk("free_rvalid", 32'(rvalid_o), 1);
    chk("free_rid", 32'(rid_o), 2);
    tick();
    req_i = 1'b0;
    #1 chk("reuse_src", 32'(a_bits_source), 2);
    d_send(8'd3, 3'd1, 1'b0, 32'h33);
    tick();
    d_valid = 1'b0;
    #1 chk("rid3", 32'(rid_o), 3);

    // Watchdog with IDs 0,1,2 outstanding
    repeat (1000) tick();
    chk("wd_before", 32'(timeout_o), 0);
    repeat (40) tick();
    chk("wd_after", 32'(timeout_o), 1);
    req_i = 1'b1;
    #1 chk("wd_blocks_gnt", 32'(gnt_o), 0);
    tick();
    req_i = 1'b0;
    d_send(8'd5, 3'd1, 1'b0, 32'h55);
    tick();
    d_valid = 1'b0;
    #1;
    chk("src5_rvalid", 32'(rvalid_o), 0);
    chk("src5_unexp", 32'(unexp_rsp_o), 1);
    d_send(8'd0, 3'd1, 1'b0, 32'h1111);
    tick();
    d_valid = 1'b0;
    #1;
    chk("late_ok_rvalid", 32'(rvalid_o), 1);
    chk("late_ok_rdata", rdata_o, 32'h1111);

    // Reset with IDs 1,2 outstanding, then a late response
    rst_ni = 1'b0;
    tick();
    chk("mid_rst_timeout", 32'(timeout_o), 0);
    chk("mid_rst_unexp", 32'(unexp_rsp_o), 0);
    chk("mid_rst_rdata", rdata_o, 0);
    chk("mid_rst_a_valid", 32'(a_valid), 0);
    rst_ni = 1'b1;
    tick();
    chk("mid_rst_d_ready", 32'(d_ready), 1);
    d_send(8'd1, 3'd1, 1'b0, 32'h99);
    tick();
    d_valid = 1'b0;
    #1;
    chk("post_rst_rvalid", 32'(rvalid_o), 0);
    chk("post_rst_unexp", 32'(unexp_rsp_o), 1);
    req_i = 1'b1;
    #1 chk("post_rst_gnt", 32'(gnt_o), 1);
    tick();
    req_i = 1'b0;
    #1 chk("post_rst_src", 32'(a_bits_source), 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
